// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the integer pipeline.
//   - XLEN_DEF / RA_W_DEF : default datapath and register-index widths
//   - alu_op_e            : ALU operation codes driven on alu_func
//   - src1_sel_e          : ALU operand-1 source select encodings
//   - src2_sel_e          : ALU operand-2 source select encodings
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_EQ    = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_SLT   = 4'b0100,
        ALU_AND   = 4'b0101,
        ALU_OR    = 4'b0110,
        ALU_XOR   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SLL   = 4'b1001,
        ALU_PASS2 = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_e;

    typedef enum logic {
        SRC2_RS  = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Single-operand priority forwarder. Selects the newest in-flight value for
// one source register: MEM-stage result first, then WB-stage result, then the
// value read from the register file at decode. Register x0 is never forwarded.
// Ports:
//   rs, rs_data             : registered source index and register-file data
//   mem_rf_we/mem_rd/mem_data : MEM-stage writeback candidate
//   wb_rf_we/wb_rd/wb_data    : WB-stage writeback candidate
//   fwd_data                : resolved operand value
// ---------------------------------------------------------------------------
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic            mem_rf_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_rf_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_rf_we && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_rf_we  && (wb_rd  != '0) && (wb_rd  == rs);

    // MEM is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_data = rs_data;
        if (mem_hit) begin
            fwd_data = mem_data;
        end else if (wb_hit) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   stall, flush               : hold contents / replace contents with bubble
//   id_*                       : decoded instruction fields from ID
//   mem_rf_we, mem_rd, mem_fwd_data : MEM-stage forwarding source
//   wb_rf_we, wb_rd, wb_data   : WB-stage forwarding source
//   load_use_stall             : freeze request to PC and IF/ID
//   ex_valid, ex_rf_we, ex_mem_re, ex_mem_we, ex_rd, ex_pc : registered fields
//   alu_func, alu_src1, alu_src2 : ALU controls and forwarded operands
//   ex_store_data              : forwarded rs2 for stores
// ---------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [3:0]      id_alu_func,
    input  logic [1:0]      id_src1_sel,
    input  logic            id_src2_sel,
    input  logic            id_rf_we,
    input  logic            id_mem_re,
    input  logic            id_mem_we,
    input  logic            mem_rf_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_rf_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            load_use_stall,
    output logic            ex_valid,
    output logic            ex_rf_we,
    output logic            ex_mem_re,
    output logic            ex_mem_we,
    output logic [RA_W-1:0] ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [3:0]      alu_func,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] ex_store_data
);

    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [RA_W-1:0] ex_rs1;
    logic [RA_W-1:0] ex_rs2;
    logic [1:0]      ex_src1_sel;
    logic            ex_src2_sel;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    logic load_use_hazard;
    logic bubble;
    logic cap_ctl;

    // A load in EX whose result is needed by the instruction in ID cannot be
    // forwarded in time; the dependent instruction must wait one cycle.
    assign load_use_hazard = id_valid && ex_valid && ex_mem_re && (ex_rd != '0) &&
                             ((id_rs1_used && (id_rs1 == ex_rd)) ||
                              (id_rs2_used && (id_rs2 == ex_rd)));

    // An external stall freezes the whole pipe, so there is nothing to
    // separate; a flush discards ID anyway, so IF/ID need not be held.
    assign load_use_stall = load_use_hazard && !stall && !flush;
    assign bubble         = flush || load_use_stall;

    // Controls of an empty decode slot must never reach EX.
    assign cap_ctl = id_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid    <= 1'b0;
            ex_rf_we    <= 1'b0;
            ex_mem_re   <= 1'b0;
            ex_mem_we   <= 1'b0;
            alu_func    <= '0;
            ex_rd       <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_src1_sel <= '0;
            ex_src2_sel <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_rf_we    <= 1'b0;
            ex_mem_re   <= 1'b0;
            ex_mem_we   <= 1'b0;
            alu_func    <= '0;
            ex_rd       <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_src1_sel <= '0;
            ex_src2_sel <= 1'b0;
        end else if (!stall) begin
            ex_valid    <= cap_ctl;
            ex_rf_we    <= cap_ctl && id_rf_we;
            ex_mem_re   <= cap_ctl && id_mem_re;
            ex_mem_we   <= cap_ctl && id_mem_we;
            alu_func    <= cap_ctl ? id_alu_func : 4'b0000;
            ex_rd       <= id_rd;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_src1_sel <= id_src1_sel;
            ex_src2_sel <= id_src2_sel;
        end
    end

    fwd_mux #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_fwd_rs1 (
        .rs        (ex_rs1),
        .rs_data   (ex_rs1_data),
        .mem_rf_we (mem_rf_we),
        .mem_rd    (mem_rd),
        .mem_data  (mem_fwd_data),
        .wb_rf_we  (wb_rf_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_data  (fwd_rs1)
    );

    fwd_mux #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_fwd_rs2 (
        .rs        (ex_rs2),
        .rs_data   (ex_rs2_data),
        .mem_rf_we (mem_rf_we),
        .mem_rd    (mem_rd),
        .mem_data  (mem_fwd_data),
        .wb_rf_we  (wb_rf_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_data  (fwd_rs2)
    );

    // Encoding 3 is unused and treated like ZERO.
    always_comb begin
        alu_src1 = '0;
        case (ex_src1_sel)
            SRC1_RS1: alu_src1 = fwd_rs1;
            SRC1_PC:  alu_src1 = ex_pc;
            default:  alu_src1 = '0;
        endcase
    end

    assign alu_src2      = (ex_src2_sel == SRC2_IMM) ? ex_imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. The stimulus process drives ID and hazard
// inputs and queues expected values tagged with the cycle they are due; the
// monitor samples outputs on each falling edge and retires due entries.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int XL = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          stall, flush;
    logic          id_valid;
    logic [XL-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used;
    logic [3:0]    id_alu_func;
    logic [1:0]    id_src1_sel;
    logic          id_src2_sel;
    logic          id_rf_we, id_mem_re, id_mem_we;
    logic          mem_rf_we;
    logic [RW-1:0] mem_rd;
    logic [XL-1:0] mem_fwd_data;
    logic          wb_rf_we;
    logic [RW-1:0] wb_rd;
    logic [XL-1:0] wb_data;
    logic          load_use_stall;
    logic          ex_valid, ex_rf_we, ex_mem_re, ex_mem_we;
    logic [RW-1:0] ex_rd;
    logic [XL-1:0] ex_pc;
    logic [3:0]    alu_func;
    logic [XL-1:0] alu_src1, alu_src2, ex_store_data;

    typedef enum {F_VALID, F_FUNC, F_SRC1, F_SRC2, F_STORE, F_RFWE,
                  F_MEMRE, F_MEMWE, F_LUS, F_RD, F_PC} field_e;

    typedef struct {
        string         name;
        field_e        field;
        logic [31:0]   value;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    id_ex_stage #(.XLEN(XL), .RA_W(RW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_alu_func    (id_alu_func),
        .id_src1_sel    (id_src1_sel),
        .id_src2_sel    (id_src2_sel),
        .id_rf_we       (id_rf_we),
        .id_mem_re      (id_mem_re),
        .id_mem_we      (id_mem_we),
        .mem_rf_we      (mem_rf_we),
        .mem_rd         (mem_rd),
        .mem_fwd_data   (mem_fwd_data),
        .wb_rf_we       (wb_rf_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .ex_rf_we       (ex_rf_we),
        .ex_mem_re      (ex_mem_re),
        .ex_mem_we      (ex_mem_we),
        .ex_rd          (ex_rd),
        .ex_pc          (ex_pc),
        .alu_func       (alu_func),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .ex_store_data  (ex_store_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(field_e f);
        case (f)
            F_VALID: return 32'(ex_valid);
            F_FUNC:  return 32'(alu_func);
            F_SRC1:  return alu_src1;
            F_SRC2:  return alu_src2;
            F_STORE: return ex_store_data;
            F_RFWE:  return 32'(ex_rf_we);
            F_MEMRE: return 32'(ex_mem_re);
            F_MEMWE: return 32'(ex_mem_we);
            F_LUS:   return 32'(load_use_stall);
            F_RD:    return 32'(ex_rd);
            F_PC:    return ex_pc;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: retire every queued expectation that is due this cycle.
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].due <= cyc) begin
                got = sample(sb[i].field);
                checks++;
                if (sb[i].due < cyc)
                    $display("[TB] FAIL %s: checked late at cycle %0d, got 0x%0h expected 0x%0h",
                             sb[i].name, cyc, got, sb[i].value);
                else if (got !== sb[i].value)
                    $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", sb[i].name, got, sb[i].value);
                else
                    passed++;
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic checkOutput(input string name, input field_e f,
                               input logic [31:0] value, input int lat);
        exp_t e;
        e.name  = name;
        e.field = f;
        e.value = value;
        e.due   = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [31:0] d1,
                                 input logic [4:0] rs2, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic [4:0] rd,
                                 input logic [3:0] func, input logic [1:0] s1,
                                 input logic s2, input logic rfwe, input logic memre,
                                 input logic u1, input logic u2);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs1_data = d1;
        id_rs2      = rs2;
        id_rs2_data = d2;
        id_imm      = imm;
        id_rd       = rd;
        id_alu_func = func;
        id_src1_sel = s1;
        id_src2_sel = s2;
        id_rf_we    = rfwe;
        id_mem_re   = memre;
        id_mem_we   = 1'b0;
        id_rs1_used = u1;
        id_rs2_used = u2;
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_rf_we = 1'b0; mem_rd = '0; mem_fwd_data = '0;
        wb_rf_we = 1'b0; wb_rd = '0; wb_data = '0;
        applyStimulus(1'b1, 32'h100, 5'd1, 32'h10, 5'd0, 32'h0, 32'hFFFF_FFF0, 5'd3,
                      ALU_ADD, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset held with a valid instruction in ID.
        repeat (3) begin
            tick();
            checkOutput("rst_valid", F_VALID, 32'h0, 0);
            checkOutput("rst_func",  F_FUNC,  32'h0, 0);
            checkOutput("rst_src1",  F_SRC1,  32'h0, 0);
            checkOutput("rst_rfwe",  F_RFWE,  32'h0, 0);
        end
        tick();
        rstn = 1'b1;
        checkOutput("cap_valid", F_VALID, 32'h1, 1);
        checkOutput("cap_src1",  F_SRC1,  32'h10, 1);
        checkOutput("cap_src2",  F_SRC2,  32'hFFFF_FFF0, 1);
        checkOutput("cap_pc",    F_PC,    32'h100, 1);
        checkOutput("cap_rd",    F_RD,    32'h3, 1);
        checkOutput("cap_memwe", F_MEMWE, 32'h0, 1);

        // Forwarding priority on an R-type with rs1=5, rs2=6.
        tick();
        applyStimulus(1'b1, 32'h104, 5'd5, 32'h1234, 5'd6, 32'h600, 32'h0, 5'd8,
                      ALU_SUB, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("sub_func", F_FUNC, 32'(ALU_SUB), 1);
        tick();
        mem_rf_we = 1'b1; mem_rd = 5'd5; mem_fwd_data = 32'hAAAA;
        wb_rf_we  = 1'b1; wb_rd  = 5'd5; wb_data      = 32'hBBBB;
        checkOutput("fwd_mem_pri", F_SRC1, 32'hAAAA, 0);
        checkOutput("fwd_rs2_none", F_SRC2, 32'h600, 0);
        tick();
        mem_rf_we = 1'b0;
        checkOutput("fwd_wb", F_SRC1, 32'hBBBB, 0);
        tick();
        mem_rf_we = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        checkOutput("fwd_rd0", F_SRC1, 32'h1234, 0);
        tick();
        mem_rd = 5'd6; wb_rd = 5'd5;
        checkOutput("fwd_rs2_mem", F_SRC2,  32'hAAAA, 0);
        checkOutput("store_mem",   F_STORE, 32'hAAAA, 0);
        checkOutput("fwd_rs1_wb",  F_SRC1,  32'hBBBB, 0);
        tick();
        mem_rf_we = 1'b0; wb_rd = 5'd6;
        checkOutput("store_wb", F_STORE, 32'hBBBB, 0);

        // x0 as a source with MEM/WB both writing x0.
        tick();
        mem_rf_we = 1'b1; mem_rd = 5'd0; wb_rf_we = 1'b1; wb_rd = 5'd0;
        applyStimulus(1'b1, 32'h108, 5'd0, 32'h77, 5'd0, 32'h0, 32'h0, 5'd9,
                      ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("x0_nofwd", F_SRC1, 32'h77, 1);
        tick();
        tick();
        mem_rf_we = 1'b0; wb_rf_we = 1'b0;

        // Operand-1 select: PC, then unused encoding 3.
        applyStimulus(1'b1, 32'h200, 5'd1, 32'h99, 5'd0, 32'h0, 32'h5, 5'd2,
                      ALU_ADD, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("src1_pc",  F_SRC1, 32'h200, 1);
        checkOutput("src2_imm", F_SRC2, 32'h5, 1);
        tick();
        applyStimulus(1'b1, 32'h204, 5'd1, 32'hFFFF, 5'd0, 32'h0, 32'h0, 5'd2,
                      ALU_OR, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("src1_sel3", F_SRC1, 32'h0, 1);

        // Load-use: load x7 then an instruction reading x7 through rs2.
        tick();
        applyStimulus(1'b1, 32'h300, 5'd1, 32'h1000, 5'd0, 32'h0, 32'h8, 5'd7,
                      ALU_ADD, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("load_memre", F_MEMRE, 32'h1, 1);
        tick();
        applyStimulus(1'b1, 32'h304, 5'd2, 32'h20, 5'd7, 32'h30, 32'h0, 5'd4,
                      ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("lu_assert", F_LUS,   32'h1, 0);
        checkOutput("lu_bubble", F_VALID, 32'h0, 1);
        checkOutput("lu_bubble_rfwe", F_RFWE, 32'h0, 1);
        tick();
        checkOutput("lu_release", F_LUS,   32'h0, 0);
        checkOutput("lu_issue",   F_VALID, 32'h1, 1);
        checkOutput("lu_issue_pc", F_PC,   32'h304, 1);

        // Load-use masked by external stall and by an empty ID slot.
        tick();
        applyStimulus(1'b1, 32'h310, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9,
                      ALU_ADD, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h314, 5'd9, 32'h0, 5'd0, 32'h0, 32'h0, 5'd4,
                      ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        stall = 1'b1;
        checkOutput("lu_stall_mask", F_LUS, 32'h0, 0);
        tick();
        stall = 1'b0;
        id_valid = 1'b0;
        checkOutput("lu_invalid_mask", F_LUS, 32'h0, 0);
        checkOutput("stall_held_rd",   F_RD,  32'h9, 0);
        tick();
        checkOutput("invalid_capture", F_VALID, 32'h0, 0);
        checkOutput("invalid_rfwe",    F_RFWE,  32'h0, 0);

        // Stall holds for three cycles, then stall+flush bubbles.
        applyStimulus(1'b1, 32'h400, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd10,
                      ALU_XOR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("xor_func", F_FUNC, 32'(ALU_XOR), 1);
        tick();
        stall = 1'b1;
        applyStimulus(1'b1, 32'h500, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd11,
                      ALU_OR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            checkOutput("stall_func", F_FUNC, 32'(ALU_XOR), 0);
            checkOutput("stall_pc",   F_PC,   32'h400, 0);
            checkOutput("stall_rd",   F_RD,   32'd10, 0);
        end
        flush = 1'b1;
        checkOutput("flush_stall_rfwe",  F_RFWE,  32'h0, 1);
        checkOutput("flush_stall_func",  F_FUNC,  32'h0, 1);
        checkOutput("flush_stall_valid", F_VALID, 32'h0, 1);
        tick();
        flush = 1'b0; stall = 1'b0;

        // Flush together with a load-use hazard still yields one bubble.
        applyStimulus(1'b1, 32'h600, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd12,
                      ALU_ADD, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h604, 5'd12, 32'h0, 5'd0, 32'h0, 32'h0, 5'd4,
                      ALU_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        checkOutput("flush_lu_valid", F_VALID, 32'h0, 1);
        tick();
        flush = 1'b0;

        // Asynchronous reset between edges.
        applyStimulus(1'b1, 32'h700, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd13,
                      ALU_AND, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", F_VALID, 32'h1, 1);
        checkOutput("pre_rst_func",  F_FUNC,  32'(ALU_AND), 1);
        tick();
        tick();
        #2;
        rstn = 1'b0;
        checkOutput("async_valid", F_VALID, 32'h0, 0);
        checkOutput("async_func",  F_FUNC,  32'h0, 0);
        checkOutput("async_rfwe",  F_RFWE,  32'h0, 0);
        tick();
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            $display("[TB] FAIL %s: never checked, got 0x%0h expected 0x%0h",
                     e.name, sample(e.field), e.value);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
